spmv_stream_decoder: RTL
========================

SPMV_STREAM_DECODER -- requirements
Module: spmv_stream_decoder

Interface
REQ-001 Parameter IN_W, default 64: input word width in bits; must be a multiple of 8.
REQ-002 Parameter VAL_W, default 64: value width in bits; must be a multiple of 8.
REQ-003 Parameter IDX_W, default 32: row and column index width.
REQ-004 Parameter ROW_BITS, default 4: width of the local-row field inside a row block.
REQ-005 Parameter DICT_AW, default 8: value dictionary address width; depth is 2^DICT_AW.
REQ-006 Parameter BUF_BYTES, default 32: byte-buffer capacity; must be at least IN_W/8 + VAL_W/8 + 3.
REQ-007 clk  in  1  clock; all logic is on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 in_valid / in_ready / in_data  in / out / in  1 / 1 / IN_W  packet byte stream; byte k is in_data[8k+7:8k], and byte 0 is oldest.
REQ-010 dict_wr / dict_data  in / in  1 / VAL_W  dictionary load port.
REQ-011 out_valid / out_ready  out / in  1 / 1  decoded-entry handshake.
REQ-012 out_value / out_row / out_col  out  VAL_W / IDX_W / IDX_W  decoded matrix entry.
REQ-013 done / err  out / out  1 / 1  sticky end-of-stream flag and sticky format-error flag.

Function
REQ-014 The header is buffer byte 0: H[2:0] is the opcode and H[7:3] is d0. The opcode sets packet length L and the delta, with V = VAL_W/8:
- op0 ROWBLK_END: L=1.
- op1 DICT_SHORT: L=2; byte1 is the dictionary address; delta = d0.
- op2 DICT_LONG: L=4; byte1 is the address; delta = {byte3, byte2, d0}.
- op3 LIT_SHORT: L=1+V; bytes 1..V are the value (little-endian); delta = d0.
- op4 LIT_LONG: L=3+V; bytes 1..V are the value; delta = {byteV+2, byteV+1, d0}.
- op5 END: L=1.
- op6 and op7 (reserved): L=1.
REQ-015 A packet is consumed only when buffered byte count >= L, decode is not stalled, and done=0; at most one packet is consumed per cycle.
REQ-016 in_ready = !done && (BUF_BYTES - count >= IN_W/8) && !reset; an accepted word appends at byte position count, using count after any same-cycle consumption.
REQ-017 Entry ops (1-4) update position as follows:
- t = {1'b0,row_lo} + delta[ROW_BITS-1:0];
- row_lo <= t[ROW_BITS-1:0];
- col <= col + (delta >> ROW_BITS) + t[ROW_BITS];
- col wraps mod 2^IDX_W.
REQ-018 The emitted entry carries the updated position: out_row = {row_hi, row_lo_new} and out_col = col_new.
REQ-019 op0 sets row_hi <= row_hi + 1 (wrapping), row_lo <= 0 and col <= 0; it emits no entry.
REQ-020 op5 sets done=1 on the following cycle; after that, no further packets are consumed and no further words are accepted until reset.
REQ-021 op6 and op7 set err=1 (sticky), emit nothing and are otherwise skipped.
REQ-022 Latency: an entry consumed at edge N presents out_valid=1 after edge N+1 (one cycle for the dictionary read).
REQ-023 A full-throughput stream yields one entry per cycle.
REQ-024 The dictionary read is synchronous with a one-cycle latency; literal packets bypass it.
REQ-025 When out_valid=1 and out_ready=0, the outputs hold stable, including a dictionary-sourced out_value, and decoding stalls.
REQ-026 No entry is dropped or duplicated under any out_ready pattern.
REQ-027 dict_wr=1 writes dict_data at dict_wa, then dict_wa increments (wrapping at 2^DICT_AW); writes may coincide with decoding.
REQ-028 A same-address read and write in the same cycle returns the old data.
REQ-029 Count never exceeds BUF_BYTES, and in_data is ignored while in_ready=0.

Reset
REQ-030 Reset clears the following to 0: count, row_hi, row_lo, col, out_valid, done, err and dict_wa.
REQ-031 out_value, out_row and out_col read 0 after reset.
REQ-032 Dictionary contents are not cleared by reset.
REQ-033 Reset asserted mid-packet discards all buffered bytes and any pending output.

Verification
REQ-034 Reset, then LIT_SHORT with header 0x0B and value 0x1122334455667788 -> one entry: row=1, col=0, value=0x1122334455667788, out_valid 1 cycle after the packet completes.
REQ-035 Preload dict[3]=0xDEADBEEF, then position row_lo=15, col=7, then DICT_SHORT with bytes 0x09,0x03 -> entry row_lo=0, col=8, value=0xDEADBEEF.
REQ-036 At position row=0x21, col=5, send op0 (byte 0x00) -> no entry; the next LIT_SHORT with header 0x0B yields row=0x31, col=0.
REQ-037 With 4 packets queued, hold out_ready=0 for 6 cycles -> outputs stable and in_ready drops when the buffer is full; release -> 4 entries on 4 consecutive cycles, in order.
REQ-038 Send byte 0x06, then LIT_SHORT, then byte 0x05 -> err=1 and one entry; done=1 the cycle after op5 is consumed; in_ready=0 thereafter.
REQ-039 Assert reset with 5 bytes of a LIT_SHORT buffered -> no entry emitted; count=0, position=0; the next full packet decodes from row=0, col=0.

Source files
------------

// File: rtl/spmv_stream_decoder_if.sv
// spmv_stream_decoder_if: packet byte stream, dictionary load port and decoded-entry output
interface spmv_stream_decoder_if #(
   parameter int IN_W  = 64,
   parameter int VAL_W = 64,
   parameter int IDX_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             dict_wr;
   logic [VAL_W-1:0] dict_data;
   logic             out_valid;
   logic             out_ready;
   logic [VAL_W-1:0] out_value;
   logic [IDX_W-1:0] out_row;
   logic [IDX_W-1:0] out_col;
   logic             done;
   logic             err;
   modport slave (
      input  in_valid, in_data, dict_wr, dict_data, out_ready,
      output in_ready, out_valid, out_value, out_row, out_col, done, err
   );
   modport master (
      output in_valid, in_data, dict_wr, dict_data, out_ready,
      input  in_ready, out_valid, out_value, out_row, out_col, done, err
   );
endinterface

// File: rtl/spmv_stream_decoder.sv
// spmv_stream_decoder: decodes a packed sparse-matrix packet stream into (value, row, col) entries
module spmv_stream_decoder #(
   parameter int IN_W      = 64,
   parameter int VAL_W     = 64,
   parameter int IDX_W     = 32,
   parameter int ROW_BITS  = 4,
   parameter int DICT_AW   = 8,
   parameter int BUF_BYTES = 32
) (
   input logic clk,
   input logic reset,
   spmv_stream_decoder_if.slave bus
);
   localparam int IB = IN_W / 8;
   localparam int V  = VAL_W / 8;
   localparam int BW = 8 * BUF_BYTES;
   localparam int CW = $clog2(BUF_BYTES + 1);
   localparam int HW = IDX_W - ROW_BITS;
   logic [BW-1:0]       buf_q, buf_d, ins;
   logic [CW-1:0]       count_q, count_d, len, rem, sh;
   logic [HW-1:0]       row_hi_q, row_hi_d;
   logic [ROW_BITS-1:0] row_lo_q, row_lo_d;
   logic [IDX_W-1:0]    col_q, col_d, delta;
   logic [ROW_BITS:0]   t;
   logic [2:0]          op;
   logic [VAL_W-1:0]    dict_q [2**DICT_AW];
   logic [VAL_W-1:0]    rd_q, p_lit_q, out_value_q;
   logic [IDX_W-1:0]    p_row_q, p_col_q, out_row_q, out_col_q;
   logic [DICT_AW-1:0]  dict_wa_q;
   logic                p_valid_q, p_dict_q, out_valid_q, done_q, err_q;
   logic                stall, fire, accept, entry;
   // Bytes at and above count are kept zero so an accepted word can be OR-ed in
   always_comb begin
      op     = buf_q[2:0];
      len    = op == 3'd1 ? CW'(2) : op == 3'd2 ? CW'(4) : op == 3'd3 ? CW'(1 + V) : op == 3'd4 ? CW'(3 + V) : CW'(1);
      delta  = op == 3'd2 ? IDX_W'({buf_q[16 +: 16], buf_q[7:3]}) :
               op == 3'd4 ? IDX_W'({buf_q[8*(V+1) +: 16], buf_q[7:3]}) : IDX_W'(buf_q[7:3]);
      entry  = op != 3'd0 && op <= 3'd4;
      stall  = out_valid_q && !bus.out_ready;
      fire   = !done_q && !stall && count_q >= len;
      sh     = fire ? len : '0;
      rem    = count_q - sh;
      accept = bus.in_valid && bus.in_ready;
      ins    = BW'(bus.in_data) << {rem, 3'b000};
      buf_d  = (buf_q >> {sh, 3'b000}) | (accept ? ins : '0);
      count_d = rem + (accept ? CW'(IB) : '0);
      t      = {1'b0, row_lo_q} + {1'b0, delta[ROW_BITS-1:0]};
      row_hi_d = row_hi_q;
      row_lo_d = row_lo_q;
      col_d    = col_q;
      if (fire && op == 3'd0) begin
         row_hi_d = row_hi_q + HW'(1);
         row_lo_d = '0;
         col_d    = '0;
      end else if (fire && entry) begin
         row_lo_d = t[ROW_BITS-1:0];
         col_d    = col_q + (delta >> ROW_BITS) + IDX_W'(t[ROW_BITS]);
      end
   end
   // Dictionary is never reset; rd_q only moves when a packet is consumed so it holds through stalls
   always_ff @(posedge clk) begin
      if (bus.dict_wr) dict_q[dict_wa_q] <= bus.dict_data;
      if (fire) rd_q <= dict_q[DICT_AW'(buf_q[15:8])];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q       <= '0;
         count_q     <= '0;
         row_hi_q    <= '0;
         row_lo_q    <= '0;
         col_q       <= '0;
         p_valid_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         dict_wa_q   <= '0;
      end else begin
         buf_q    <= buf_d;
         count_q  <= count_d;
         row_hi_q <= row_hi_d;
         row_lo_q <= row_lo_d;
         col_q    <= col_d;
         if (bus.dict_wr) dict_wa_q <= dict_wa_q + DICT_AW'(1);
         if (fire && op == 3'd5) done_q <= 1'b1;
         if (fire && op[2:1] == 2'b11) err_q <= 1'b1;
         if (!stall) begin
            p_valid_q   <= fire && entry;
            out_valid_q <= p_valid_q;
            if (p_valid_q) begin
               out_value_q <= p_dict_q ? rd_q : p_lit_q;
               out_row_q   <= p_row_q;
               out_col_q   <= p_col_q;
            end
         end
         if (fire) begin
            p_dict_q <= op == 3'd1 || op == 3'd2;
            p_lit_q  <= buf_q[8 +: VAL_W];
            p_row_q  <= {row_hi_d, row_lo_d};
            p_col_q  <= col_d;
         end
      end
   end
   assign bus.in_ready  = !done_q && (CW'(BUF_BYTES) - count_q >= CW'(IB)) && !reset;
   assign bus.out_valid = out_valid_q;
   assign bus.out_value = out_value_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_col   = out_col_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule
